// File: rtl/read_pointer_empty_pkg.sv
// Shared pointer helpers for the async FIFO read and write sides.
// Gray/binary conversion works on 32-bit values; zero-extend narrower pointers first.
package read_pointer_empty_pkg;

  localparam int DEFAULT_ADDRESS_SIZE = 4;
  localparam int DEFAULT_SYNC_STAGES  = 2;

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return (bin >> 1) ^ bin;
  endfunction

  // Leading zeros from zero-extension leave the prefix XOR unchanged.
  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin[31] = gray[31];
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/read_pointer_empty_sync_ptr.sv
// Multi-flop synchroniser for a Gray pointer crossing into this clock domain.
// Plain flop chain with no logic between stages; synchronous active-high reset.
module sync_ptr #(
  parameter int width  = 5,
  parameter int stages = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [width-1:0] i_d,
  output logic [width-1:0] o_q
);

  logic [width-1:0] r_stage [stages];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < stages; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < stages; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_q = r_stage[stages-1];

endmodule

// File: rtl/read_pointer_empty.sv
// Read-side pointer and registered empty flag of the async FIFO.
// Optional read_almost_empty output is enabled by defining READ_ALMOST_EMPTY_EN.
module read_pointer_empty
  import read_pointer_empty_pkg::*;
#(
  parameter int address_size           = DEFAULT_ADDRESS_SIZE,
  parameter int sync_stages            = DEFAULT_SYNC_STAGES,
  parameter int almost_empty_threshold = 1
) (
  input  logic                  read_clk,
  input  logic                  read_reset,
  input  logic                  read_enable,
  input  logic [address_size:0] write_to_read_pointer,
  output logic [address_size-1:0] read_address,
  output logic [address_size:0] read_pointer,
  output logic                  read_empty
`ifdef READ_ALMOST_EMPTY_EN
  ,
  output logic                  read_almost_empty
`endif
);

  logic [address_size:0] r_binary;
  logic [address_size:0] r_gray;
  logic                  r_empty;

  logic [address_size:0] w_wq_sync;
  logic                  w_pop;
  logic [address_size:0] w_binary_next;
  logic [address_size:0] w_gray_next;

  sync_ptr #(
    .width  (address_size + 1),
    .stages (sync_stages)
  ) u_sync_wptr (
    .i_clk   (read_clk),
    .i_reset (read_reset),
    .i_d     (write_to_read_pointer),
    .o_q     (w_wq_sync)
  );

  assign w_pop         = read_enable & ~r_empty;
  assign w_binary_next = r_binary + {{address_size{1'b0}}, w_pop};
  assign w_gray_next   = (w_binary_next >> 1) ^ w_binary_next;

  // Empty looks at the next pointer so popping the last entry flags empty on the same edge.
  always_ff @(posedge read_clk) begin
    if (read_reset) begin
      r_binary <= '0;
      r_gray   <= '0;
      r_empty  <= 1'b1;
    end else begin
      r_binary <= w_binary_next;
      r_gray   <= w_gray_next;
      r_empty  <= (w_gray_next == w_wq_sync);
    end
  end

  assign read_address = r_binary[address_size-1:0];
  assign read_pointer = r_gray;
  assign read_empty   = r_empty;

`ifdef READ_ALMOST_EMPTY_EN
  logic [31:0]           w_wbin_full;
  logic [address_size:0] w_wbin;
  logic [address_size:0] w_level;
  logic                  r_almost_empty;

  assign w_wbin_full = gray2bin(32'(w_wq_sync));
  assign w_wbin      = w_wbin_full[address_size:0];
  assign w_level     = w_wbin - w_binary_next;

  always_ff @(posedge read_clk) begin
    if (read_reset) begin
      r_almost_empty <= 1'b1;
    end else begin
      r_almost_empty <= (w_level <= (address_size+1)'(almost_empty_threshold));
    end
  end

  assign read_almost_empty = r_almost_empty;
`endif

endmodule

// File: tb/tb_read_pointer_empty.sv
// Self-checking bench for read_pointer_empty: directed vector table plus wrap and mid-stream reset sequences.
// Define READ_ALMOST_EMPTY_EN to also check read_almost_empty.
module tb_read_pointer_empty;

  logic       read_clk;
  logic       read_reset;
  logic       read_enable;
  logic [4:0] write_to_read_pointer;
  logic [3:0] read_address;
  logic [4:0] read_pointer;
  logic       read_empty;
`ifdef READ_ALMOST_EMPTY_EN
  logic       read_almost_empty;
`endif

  int checkCount;
  int errorCount;

  read_pointer_empty dut (
    .read_clk              (read_clk),
    .read_reset            (read_reset),
    .read_enable           (read_enable),
    .write_to_read_pointer (write_to_read_pointer),
    .read_address          (read_address),
    .read_pointer          (read_pointer),
    .read_empty            (read_empty)
`ifdef READ_ALMOST_EMPTY_EN
    ,
    .read_almost_empty     (read_almost_empty)
`endif
  );

  initial read_clk = 1'b0;
  always #5 read_clk = ~read_clk;

  typedef struct {
    logic       rst;
    logic       re;
    logic [4:0] wptr;
    logic       expEmpty;
    logic [4:0] expPtr;
    logic [3:0] expAddr;
  } vector_t;

  vector_t vecs [18];

  task automatic applyStimulus(input logic rst, input logic re, input logic [4:0] wptr);
    read_reset            = rst;
    read_enable           = re;
    write_to_read_pointer = wptr;
    @(posedge read_clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkState(input string tag, input logic expEmpty, input logic [4:0] expPtr, input logic [3:0] expAddr);
    checkOutput({tag, " empty"}, 32'(read_empty), 32'(expEmpty));
    checkOutput({tag, " ptr"}, 32'(read_pointer), 32'(expPtr));
    checkOutput({tag, " addr"}, 32'(read_address), 32'(expAddr));
  endtask

  function automatic logic [4:0] toGray(input logic [4:0] b);
    return (b >> 1) ^ b;
  endfunction

  initial begin
    checkCount = 0;
    errorCount = 0;
    read_reset = 1'b1;
    read_enable = 1'b0;
    write_to_read_pointer = 5'b00000;

    // rst, re, wptr, expected empty/pointer/address after the edge
    vecs[0]  = '{1'b1, 1'b0, 5'b00000, 1'b1, 5'b00000, 4'd0};
    vecs[1]  = '{1'b1, 1'b0, 5'b00000, 1'b1, 5'b00000, 4'd0};
    vecs[2]  = '{1'b0, 1'b0, 5'b00001, 1'b1, 5'b00000, 4'd0};
    vecs[3]  = '{1'b0, 1'b0, 5'b00001, 1'b1, 5'b00000, 4'd0};
    vecs[4]  = '{1'b0, 1'b0, 5'b00001, 1'b0, 5'b00000, 4'd0};
    vecs[5]  = '{1'b0, 1'b0, 5'b00001, 1'b0, 5'b00000, 4'd0};
    vecs[6]  = '{1'b0, 1'b1, 5'b00001, 1'b1, 5'b00001, 4'd1};
    vecs[7]  = '{1'b0, 1'b1, 5'b00001, 1'b1, 5'b00001, 4'd1};
    vecs[8]  = '{1'b0, 1'b1, 5'b00001, 1'b1, 5'b00001, 4'd1};
    vecs[9]  = '{1'b0, 1'b1, 5'b00001, 1'b1, 5'b00001, 4'd1};
    vecs[10] = '{1'b0, 1'b1, 5'b00001, 1'b1, 5'b00001, 4'd1};
    vecs[11] = '{1'b0, 1'b1, 5'b00001, 1'b1, 5'b00001, 4'd1};
    vecs[12] = '{1'b0, 1'b0, 5'b00001, 1'b1, 5'b00001, 4'd1};
    vecs[13] = '{1'b0, 1'b1, 5'b00011, 1'b1, 5'b00001, 4'd1};
    vecs[14] = '{1'b0, 1'b1, 5'b00011, 1'b1, 5'b00001, 4'd1};
    vecs[15] = '{1'b0, 1'b1, 5'b00011, 1'b0, 5'b00001, 4'd1};
    vecs[16] = '{1'b0, 1'b1, 5'b00011, 1'b1, 5'b00011, 4'd2};
    vecs[17] = '{1'b0, 1'b1, 5'b00011, 1'b1, 5'b00011, 4'd2};

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].re, vecs[i].wptr);
      checkState($sformatf("vec%0d", i), vecs[i].expEmpty, vecs[i].expPtr, vecs[i].expAddr);
`ifdef READ_ALMOST_EMPTY_EN
      if (i < 2) checkOutput($sformatf("vec%0d almost", i), 32'(read_almost_empty), 32'd1);
`endif
    end

    // Wrap: write pointer at binary 16, pop all 16 entries from a fresh reset
    applyStimulus(1'b1, 1'b0, 5'b11000);
    checkState("wrap reset", 1'b1, 5'b00000, 4'd0);
    for (int e = 1; e <= 3; e++) begin
      applyStimulus(1'b0, 1'b0, 5'b11000);
      checkOutput($sformatf("wrap sync%0d empty", e), 32'(read_empty), (e == 3) ? 32'd0 : 32'd1);
`ifdef READ_ALMOST_EMPTY_EN
      checkOutput($sformatf("wrap sync%0d almost", e), 32'(read_almost_empty), (e == 3) ? 32'd0 : 32'd1);
`endif
    end
    for (int k = 1; k <= 16; k++) begin
      logic [4:0] kb;
      kb = 5'(k);
      applyStimulus(1'b0, 1'b1, 5'b11000);
      checkState($sformatf("wrap pop%0d", k), (k == 16), toGray(kb), kb[3:0]);
`ifdef READ_ALMOST_EMPTY_EN
      checkOutput($sformatf("wrap pop%0d almost", k), 32'(read_almost_empty), (k >= 15) ? 32'd1 : 32'd0);
`endif
    end
    applyStimulus(1'b0, 1'b1, 5'b11000);
    checkState("wrap hold", 1'b1, 5'b11000, 4'd0);

    // Mid-stream reset: pop to binary 5, then reset with read_enable still high
    applyStimulus(1'b1, 1'b0, 5'b11000);
    for (int e = 0; e < 3; e++) applyStimulus(1'b0, 1'b0, 5'b11000);
    for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b1, 5'b11000);
    checkState("mid pre", 1'b0, 5'b00111, 4'd5);
    applyStimulus(1'b1, 1'b1, 5'b11000);
    checkState("mid reset", 1'b1, 5'b00000, 4'd0);
    for (int e = 1; e <= 3; e++) begin
      applyStimulus(1'b0, 1'b0, 5'b11000);
      checkState($sformatf("mid resync%0d", e), (e != 3), 5'b00000, 4'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
